mcse_resource_arbiter: RTL
==========================

Name: mcse_resource_arbiter

Overview:
- Parametrised N-requester arbiter for the MCSE shared resources: secure memory port, bus translation port and SHA core.
- Generalises the fixed 2-way secure-boot/FW-auth select into registered grant ownership.
- Adds fixed-priority or round-robin selection, payload and response steering, and a forced-revoke watchdog.
- Sits inside the control unit between the boot sub-controllers and the shared resources.

Parameters:
N_REQ, 4, number of requesters (2..16)
PAYLOAD_W, 128, width of each requester's flattened command payload (mem + bus + sha fields)
RSP_W, 128, width of the resource response data
ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round robin
TIMEOUT_CYCLES, 4096, maximum ownership length before forced revoke (used only with MCSE_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester ownership request (level)
req_payload  input  N_REQ*PAYLOAD_W  requester i command at bits [i*PAYLOAD_W +: PAYLOAD_W]
gnt  output  N_REQ  one-hot registered grant
res_payload  output  PAYLOAD_W  command forwarded to shared resources
res_rsp_valid  input  1  resource response strobe (mem rdData_valid / bus done / sha digest_valid, ORed upstream)
res_rsp_data  input  RSP_W  resource response data
rsp_valid  output  N_REQ  response strobe steered to the owner only
rsp_data  output  RSP_W  response data, broadcast, qualified by rsp_valid
owner_id  output  $clog2(N_REQ)  index of current owner, 0 when idle
busy  output  1  high while any grant is held
timeout_err  output  1  one-cycle pulse on forced revoke
timeout_id  output  $clog2(N_REQ)  requester revoked by last timeout, sticky until next timeout or reset

Behaviour:
- Reset (rst high at clk edge): state IDLE; gnt=0, owner_id=0, busy=0, timeout_err=0, timeout_id=0; RR pointer=0; revoke mask=0.
- Reset mid-ownership drops the grant the same edge with no drain; the payload is zero from the next cycle.
- FSM states: IDLE, OWNED, GAP.
- IDLE: if (req & ~mask) is non-zero, choose winner; gnt/owner_id/busy registered. Latency req→gnt is 1 cycle. Go to OWNED.
- Fixed priority: lowest set index wins.
- Round robin: first set index at or after the pointer, wrapping N_REQ-1→0. Pointer := winner+1 mod N_REQ on each grant.
- OWNED: res_payload = owner's slice (combinational mux from the registered owner).
- OWNED response steering: rsp_valid[owner] = res_rsp_valid, other bits 0; rsp_data = res_rsp_data.
- Ownership is held while req[owner]=1; other requests are ignored, with no preemption.
- Owner deasserts req: gnt drops next edge, go to GAP.
- GAP: exactly one cycle with gnt=0 and res_payload=0, guaranteeing no command overlap between owners; then IDLE.
- Back-to-back handoff: the minimum gap from one owner's release to the next gnt is 2 cycles.
- Outside OWNED: res_payload=0 and rsp_valid=0; any res_rsp_valid is dropped.
- A requester that deasserts then reasserts req in the same GAP cycle is rearbitrated normally.
- A single requester with continuous req is never starved: it is regranted after each GAP.
- Simultaneous release by the owner and a new req: the release takes effect first; the new req competes in IDLE.
- mask bit i is set by a timeout revoke and cleared when req[i] is observed low.

Optional Feature:
- MCSE_ARB_TIMEOUT_EN defined:
  - Ownership counter clears on grant and increments each OWNED cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with req[owner] still high: drop gnt next edge, pulse timeout_err for 1 cycle, load timeout_id, set mask[owner], go to GAP.
  - A masked requester cannot win until it drops req.
- Not defined: no counter, timeout_err tied 0, timeout_id tied 0, mask never set; ownership is unbounded.

Test Plan:
- Reset then req=4'b0000 for 10 cycles → gnt=0, busy=0, res_payload=0 throughout.
- ARB_MODE=0, req=4'b1010 at cycle 0 → gnt=4'b0010 at cycle 1, owner_id=1. Payload slice 1 = 0xA5A5... appears on res_payload. Drop req[1] → gnt=0 for 2 cycles, then gnt=4'b1000.
- ARB_MODE=1, req=4'b1111 held, each owner releases after 3 cycles → grant order 0,1,2,3,0, each separated by one GAP cycle.
- Owner 2 holds, res_rsp_valid pulsed with data 0x1234 → rsp_valid=4'b0100, rsp_data=0x1234. Same pulse during GAP → rsp_valid=0.
- MCSE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req[0] stuck high, req[3] high:
  - timeout_err pulses 16 cycles after gnt[0]; timeout_id=0.
  - gnt=4'b1000 after GAP.
  - Requester 0 is not regranted until req[0] is toggled low.
- Assert rst while owner 3 holds → next cycle gnt=0, busy=0, owner_id=0. After rst release with req[3] still high, fixed mode → gnt=4'b1000 one cycle later.

Source files
------------

// File: rtl/mcse_resource_arbiter.sv
// mcse_resource_arbiter
// ---------------------
// Arbitrates ownership of the MCSE shared resources (secure memory port,
// bus translation port, SHA core) between N_REQ boot sub-controllers.
//   * Ownership is registered and one-hot (gnt). The owner keeps it for as
//     long as it holds req. There is no preemption.
//   * Selection is fixed priority (ARB_MODE=0, index 0 highest) or round
//     robin (ARB_MODE=1, pointer advances past each winner).
//   * After every release there is one GAP cycle with no grant and a zero
//     command, so commands from two owners can never overlap.
//   * The owner's command slice is steered to res_payload, and the resource
//     response strobe is steered back to the owner only.
// Optional feature macro: MCSE_ARB_TIMEOUT_EN
//   Defined   : the owner is forcibly revoked after TIMEOUT_CYCLES owned
//               cycles. timeout_err pulses, timeout_id records the victim,
//               and the victim is masked until it drops req.
//   Undefined : ownership is unbounded; timeout_err/timeout_id are tied 0.

module mcse_resource_arbiter #(
    parameter int N_REQ          = 4,
    parameter int PAYLOAD_W      = 128,
    parameter int RSP_W          = 128,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*PAYLOAD_W-1:0]   req_payload,
    output logic [N_REQ-1:0]             gnt,
    output logic [PAYLOAD_W-1:0]         res_payload,
    input  logic                         res_rsp_valid,
    input  logic [RSP_W-1:0]             res_rsp_data,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [RSP_W-1:0]             rsp_data,
    output logic [$clog2(N_REQ)-1:0]     owner_id,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [$clog2(N_REQ)-1:0]     timeout_id
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Elaboration-time guard against unsupported configurations.
    if ((N_REQ < 2) || (N_REQ > 16) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
        $error("mcse_resource_arbiter: unsupported parameter set");
    end

    // Index of the lowest set bit of v (0 when v is empty).
    function automatic logic [IDW-1:0] lowest_idx(input logic [N_REQ-1:0] v);
        logic [IDW-1:0] r;
        r = {IDW{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            r = v[i] ? IDW'(i) : r;
        end
        return r;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] r;
        r = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            r[i] = (idx == IDW'(i));
        end
        return r;
    endfunction

    // State and registered outputs.
    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] mask_q, mask_d;

    // Arbitration and steering helpers.
    logic [N_REQ-1:0]     cand_s;
    logic [N_REQ-1:0]     rot_s;
    logic [IDW:0]         rr_sum_s;
    logic [IDW-1:0]       rr_win_s;
    logic [IDW-1:0]       win_idx_s;
    logic                 win_found_s;
    logic [IDW-1:0]       ptr_next_s;
    logic                 to_hit_s;
    logic [PAYLOAD_W-1:0] res_payload_s;

    // Pick the winner among unmasked requesters for the selected policy.
    always_comb begin
        cand_s      = req & ~mask_q;
        win_found_s = |cand_s;
        // Rotate so the pointer position lands at bit 0, then take the first
        // set bit and map the offset back into requester index space.
        rot_s       = N_REQ'({cand_s, cand_s} >> ptr_q);
        rr_sum_s    = {1'b0, ptr_q} + {1'b0, lowest_idx(rot_s)};
        if (rr_sum_s >= (IDW+1)'(N_REQ)) begin
            rr_win_s = IDW'(rr_sum_s - (IDW+1)'(N_REQ));
        end else begin
            rr_win_s = rr_sum_s[IDW-1:0];
        end
        if (ARB_MODE == 0) begin
            win_idx_s = lowest_idx(cand_s);
        end else begin
            win_idx_s = rr_win_s;
        end
        if (win_idx_s == IDW'(N_REQ - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = win_idx_s + IDW'(1);
        end
    end

    // Ownership FSM: IDLE -> OWNED -> GAP -> IDLE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        // A mask bit is released as soon as its requester is seen low.
        mask_d  = mask_q & req;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_OWNED;
                    gnt_d   = onehot(win_idx_s);
                    owner_d = win_idx_s;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_next_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!req[owner_q]) begin
                    state_d = ST_GAP;
                    gnt_d   = {N_REQ{1'b0}};
                    owner_d = {IDW{1'b0}};
                    busy_d  = 1'b0;
                end else if (to_hit_s) begin
                    state_d = ST_GAP;
                    gnt_d   = {N_REQ{1'b0}};
                    owner_d = {IDW{1'b0}};
                    busy_d  = 1'b0;
                    mask_d  = (mask_q & req) | onehot(owner_q);
                end else begin
                    state_d = ST_OWNED;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N_REQ{1'b0}};
                owner_d = {IDW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and ownership registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= {N_REQ{1'b0}};
            owner_q <= {IDW{1'b0}};
            busy_q  <= 1'b0;
            ptr_q   <= {IDW{1'b0}};
            mask_q  <= {N_REQ{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
        end
    end

`ifdef MCSE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic [IDW-1:0]   tid_q, tid_d;

    assign to_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Ownership length counter plus the revoke pulse and sticky victim id.
    always_comb begin
        if (state_q == ST_OWNED) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            // Held at zero outside ownership, so every grant starts at zero.
            cnt_d = {CNT_W{1'b0}};
        end
        terr_d = (state_q == ST_OWNED) && req[owner_q] && to_hit_s;
        if (terr_d) begin
            tid_d = owner_q;
        end else begin
            tid_d = tid_q;
        end
    end

    // Timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            terr_q <= 1'b0;
            tid_q  <= {IDW{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
            tid_q  <= tid_d;
        end
    end

    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;
`else
    assign to_hit_s    = 1'b0;
    assign timeout_err = 1'b0;
    assign timeout_id  = {IDW{1'b0}};
`endif

    // Forward the owner's command slice; zero whenever nobody owns.
    always_comb begin
        res_payload_s = {PAYLOAD_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if ((state_q == ST_OWNED) && (owner_q == IDW'(i))) begin
                res_payload_s = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end else begin
                res_payload_s = res_payload_s;
            end
        end
    end

    assign res_payload = res_payload_s;
    // gnt_q is the owner's one-hot, so it doubles as the response steer.
    assign rsp_valid   = ((state_q == ST_OWNED) && res_rsp_valid) ? gnt_q : {N_REQ{1'b0}};
    assign rsp_data    = res_rsp_data;
    assign gnt         = gnt_q;
    assign owner_id    = owner_q;
    assign busy        = busy_q;

endmodule
